// File: rtl/spi_slave_if.sv
// spi_slave_if: parallel register/memory access port of the SPI responder.
// The responder owns the request side (master modport); the register file
// or memory behind it answers through read_data (slave modport).
interface spi_slave_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 15
);
  logic                     write_enable;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     read_request;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0]    read_data;

  modport master (
    output write_enable, write_address, write_data,
    output read_request, read_address,
    input  read_data
  );

  modport slave (
    input  write_enable, write_address, write_data,
    input  read_request, read_address,
    output read_data
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: decodes spi_master frames (rw bit, address, data word; MSB first)
// into a parallel register access port. Serial lines are oversampled in the
// clock domain through 2-flop synchronizers; all four CPOL/CPHA modes.
// Optional feature macro: SPI_SLAVE_BURST_EN -- auto-incrementing burst that
// accepts further data words while chip select stays low. Without it the block
// handles one word per frame and ignores the rest of the frame.
module spi_slave #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_polarity,
  input  logic        clock_phase,
  input  logic        serial_clock,
  input  logic        chip_select,
  input  logic        serial_in,
  output logic        serial_out,
  output logic        busy,
  output logic        frame_error,
  output logic [15:0] word_count,
  spi_slave_if.master bus
);

  localparam int COMMAND_COUNT_WIDTH = $clog2(ADDRESS_WIDTH + 1);
  localparam int DATA_COUNT_WIDTH    = $clog2(DATA_WIDTH);
  localparam int COUNT_WIDTH = (COMMAND_COUNT_WIDTH > DATA_COUNT_WIDTH) ?
                               COMMAND_COUNT_WIDTH : DATA_COUNT_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] LAST_COMMAND_BIT = COUNT_WIDTH'(ADDRESS_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_DATA_BIT    = COUNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    COMMAND,
    WRITE_DATA,
    READ_DATA,
    HOLD
  } state_t;

  state_t state, next_state;

  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;

  logic leading_edge, trailing_edge, sample_edge, shift_edge, cs_fall;

  logic [COUNT_WIDTH-1:0]   bit_count;
  logic [ADDRESS_WIDTH-1:0] command_shift;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [ADDRESS_WIDTH-1:0] received_address;
  logic [ADDRESS_WIDTH-1:0] next_address;
  logic [DATA_WIDTH-1:0]    data_shift;
  logic [DATA_WIDTH-1:0]    shift_out;
  logic                     load_pending;

  logic start_frame, abort_frame, command_bit, command_done;
  logic data_bit, word_done, read_shift;

  assign busy             = (state != IDLE);
  assign received_address = {command_shift[ADDRESS_WIDTH-2:0], mosi_sync};
  assign next_address     = address + 1'b1;

  // Synchronize the asynchronous serial lines; chip select flops clear low so a
  // frame cut by reset is never mistaken for a fresh chip select fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      cs_meta   <= 1'b0;
      cs_sync   <= 1'b0;
      cs_prev   <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= serial_clock;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= chip_select;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      mosi_meta <= serial_in;
      mosi_sync <= mosi_meta;
    end
  end

  // Classify serial clock transitions into sample and shift edges for the mode.
  always_comb begin
    leading_edge  = (sclk_sync != sclk_prev) && (sclk_prev == clock_polarity);
    trailing_edge = (sclk_sync != sclk_prev) && (sclk_sync == clock_polarity);
    sample_edge   = clock_phase ? trailing_edge : leading_edge;
    shift_edge    = clock_phase ? leading_edge : trailing_edge;
    cs_fall       = cs_prev && !cs_sync;
  end

  // Frame state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the per-cycle decisions the datapath acts on.
  always_comb begin
    next_state   = state;
    start_frame  = 1'b0;
    abort_frame  = 1'b0;
    command_bit  = 1'b0;
    command_done = 1'b0;
    data_bit     = 1'b0;
    word_done    = 1'b0;
    read_shift   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          start_frame = 1'b1;
          next_state  = COMMAND;
        end
      end
      COMMAND: begin
        if (cs_sync) begin
          abort_frame = 1'b1;
          next_state  = IDLE;
        end else if (sample_edge) begin
          command_bit = 1'b1;
          if (bit_count == LAST_COMMAND_BIT) begin
            command_done = 1'b1;
            next_state   = command_shift[ADDRESS_WIDTH-1] ? READ_DATA : WRITE_DATA;
          end
        end
      end
      WRITE_DATA, READ_DATA: begin
        if (cs_sync) begin
          abort_frame = 1'b1;
          next_state  = IDLE;
        end else begin
          read_shift = (state == READ_DATA) && shift_edge;
          if (sample_edge) begin
            data_bit = 1'b1;
            if (bit_count == LAST_DATA_BIT) begin
              word_done = 1'b1;
`ifdef SPI_SLAVE_BURST_EN
              next_state = state;
`else
              next_state = HOLD;
`endif
            end
          end
        end
      end
      HOLD: begin
        if (cs_sync) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Shift registers, bit/word counters and the parallel-side strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_count         <= '0;
      command_shift     <= '0;
      address           <= '0;
      data_shift        <= '0;
      shift_out         <= '0;
      load_pending      <= 1'b0;
      serial_out        <= 1'b0;
      frame_error       <= 1'b0;
      word_count        <= '0;
      bus.write_enable  <= 1'b0;
      bus.write_address <= '0;
      bus.write_data    <= '0;
      bus.read_request  <= 1'b0;
      bus.read_address  <= '0;
    end else begin
      bus.write_enable <= 1'b0;
      bus.read_request <= 1'b0;
      frame_error      <= abort_frame && (bit_count != '0);
      load_pending     <= bus.read_request;

      if (start_frame) begin
        bit_count  <= '0;
        word_count <= '0;
      end

      if (command_bit) begin
        command_shift <= received_address;
        bit_count     <= command_done ? '0 : bit_count + 1'b1;
      end

      if (command_done) begin
        address <= received_address;
        if (command_shift[ADDRESS_WIDTH-1]) begin
          bus.read_request <= 1'b1;
          bus.read_address <= received_address;
        end
      end

      if (data_bit) begin
        data_shift <= {data_shift[DATA_WIDTH-2:0], mosi_sync};
        bit_count  <= word_done ? '0 : bit_count + 1'b1;
      end

      if (word_done) begin
        if (state == WRITE_DATA) begin
          bus.write_enable  <= 1'b1;
          bus.write_address <= address;
          bus.write_data    <= {data_shift[DATA_WIDTH-2:0], mosi_sync};
        end
`ifdef SPI_SLAVE_BURST_EN
        address    <= next_address;
        word_count <= word_count + 16'd1;
        if (state == READ_DATA) begin
          bus.read_request <= 1'b1;
          bus.read_address <= next_address;
        end
`else
        word_count <= 16'd1;
`endif
      end

      if (load_pending) begin
        shift_out <= bus.read_data;
      end else if (read_shift) begin
        shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};
      end

      if (next_state != READ_DATA) begin
        serial_out <= 1'b0;
      end else if (read_shift) begin
        serial_out <= shift_out[DATA_WIDTH-1];
      end
    end
  end

endmodule
